shift_deserializer_8bit: RTL and testbench
==========================================

# shift_deserializer_8bit

Serial-in, parallel-out receiver paired with the 8-bit parallel-load shift register. It accepts an MSB-first serial bit stream, one bit per qualified clock edge. It assembles each group of WIDTH bits into a word and presents the word on a valid/ready output port through a one-deep holding register. It sits at the receiving end of the serial link, between the serial line and the byte-consuming logic.

## Interface
- WIDTH, 8, data bits per word; legal range 2..32.
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- Reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial data bit, MSB first.
- ShiftIn  input  1  bit strobe; data_in is sampled on a posedge where ShiftIn=1.
- FrameSync  input  1  word alignment; marks the current strobed bit as the first bit (MSB) of a new word.
- parallel_out  output  WIDTH  assembled word; stable while out_valid=1.
- out_valid  output  1  parallel_out holds an unconsumed word.
- out_ready  input  1  consumer accepts the word on a posedge where out_valid=1 and out_ready=1.
- Overrun  output  1  sticky flag; a completed word was dropped because the hold register was full.
- ParityErr  output  1  present only with DESER_PARITY_EN; qualified by out_valid.

## Operation
- State:
  - shift register sr[WIDTH-1:0];
  - bit counter cnt, 0..N-1, where N=WIDTH, or WIDTH+1 with parity;
  - hold register with valid bit;
  - Overrun flag.
- Reset=1 at a posedge:
  - sr, cnt, parallel_out, out_valid, Overrun and ParityErr all go to 0.
  - Reset has priority over every other input.
  - Reset during a partial word discards that word.
- Bit accept (ShiftIn=1):
  - data bits: sr <= {sr[WIDTH-2:0], data_in}, and cnt increments;
  - first received bit ends up in parallel_out[WIDTH-1];
  - parity bit (last bit, parity build only): not shifted into sr, only checked.
- Word completion is the posedge that accepts the bit with cnt=N-1:
  - cnt wraps to 0;
  - the completed word ({sr[WIDTH-2:0], data_in}, or sr in the parity build) is offered to the hold register.
- Hold register load:
  - Loads when it is empty, or being consumed on the same edge (out_valid & out_ready).
  - Otherwise the word is dropped and Overrun <= 1.
  - Overrun stays 1 until Reset.
- Consumption:
  - out_valid & out_ready at a posedge with no load clears out_valid.
  - Completion and consumption on the same edge: parallel_out takes the new word, out_valid stays 1, no overrun.
- FrameSync with ShiftIn=1:
  - the bit is taken as bit 0 of a new word (cnt becomes 1);
  - any partial word is discarded with no flag;
  - if N=1 would be implied, not applicable, since WIDTH>=2.
- FrameSync with ShiftIn=0: cnt <= 0; the partial word is discarded.
- FrameSync never affects the hold register or Overrun.
- ShiftIn=0 and FrameSync=0: sr and cnt hold.

## Timing
- Latency: out_valid rises in the cycle after the posedge that accepted the last bit.
  - A word strobed on N consecutive edges is visible one cycle after the Nth edge.
- Maximum throughput: one bit per clock, continuous.
  - The consumer must accept within N cycles of out_valid to avoid overrun.
- out_valid, parallel_out, Overrun and ParityErr are all registered outputs; there is no combinational path from any input.
- out_ready is ignored while out_valid=0.

## Configuration
- DESER_PARITY_EN defined:
  - N=WIDTH+1; the last bit of each word is an even-parity bit.
  - ParityErr is loaded with the hold register: 1 when XOR of the WIDTH data bits and the parity bit is 1.
  - A word with a parity error is still delivered.
- DESER_PARITY_EN undefined:
  - N=WIDTH; the ParityErr port is absent.
  - No parity logic is generated.

## Structure
- Shared package shift_link_pkg holds:
  - DEFAULT_WIDTH=8;
  - the function computing cnt width, $clog2(WIDTH+1);
  - the even-parity helper function, also used by the transmitter-side parity generator.
- One sub-module, deser_hold_stage: the one-deep valid/ready holding register.
  - It covers the load/consume/drop decision and generates the Overrun pulse.
- Bit counter and shift register live in the top module.

## Test plan
- Reset: Reset=1 for 2 cycles mid-word (3 bits strobed), then 8 strobes of 1,0,1,0,1,0,1,0 with out_ready=1 -> parallel_out=8'hAA, out_valid high exactly one cycle; all outputs 0 during reset.
- Back-to-back: 16 consecutive strobes carrying 8'hAA then 8'h3C, out_ready=1 -> two single-cycle out_valid pulses 8 cycles apart, values AA then 3C, Overrun=0.
- Overrun: out_ready=0, send 8'h55 then 8'hF0 -> parallel_out stays 8'h55, Overrun=1 after the 16th strobe. Then out_ready=1 -> 55 is consumed, out_valid=0, Overrun remains 1.
- Simultaneous: out_valid=1 with 8'h11; raise out_ready exactly on the completion edge of 8'h22 -> parallel_out=8'h22 next cycle, out_valid stays 1, Overrun=0.
- FrameSync realign: strobe 5 bits, then FrameSync=1 with ShiftIn=1 on bit 1 of 8'hC3, then 7 more strobes -> single word 8'hC3, partial word discarded.
- DESER_PARITY_EN: send 8'hAA with parity bit 0 -> ParityErr=0; send 8'hAB with parity bit 0 -> ParityErr=1 with out_valid, word 8'hAB delivered.

Source files
------------

// File: rtl/shift_link_pkg.sv
// Shared definitions for the serial link: default word width, counter sizing
// and the even-parity helper used by both the transmitter and the receiver.
package shift_link_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed for a counter that must reach WIDTH (parity builds count WIDTH+1 bits).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Even parity over up to 32 bits; narrower words are zero-extended by the caller.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/deser_hold_stage.sv
// One-deep valid/ready holding register: decides load, consume or drop for each
// completed word and flags a dropped word with a single-cycle pulse.
module deser_hold_stage
  import shift_link_pkg::*;
#(
  parameter int DW = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          drop_pulse
);

  logic accept;

  // A word may enter when the slot is empty or is being drained on this edge.
  assign accept     = load_valid && (!out_valid || out_ready);
  assign drop_pulse = load_valid && out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      // NOTE: the data register is reset because the output must read 0 after
      // reset; a plain storage array with no such visibility would not be.
      out_data  <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // so the order of statements here cannot change the result.
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_deserializer_8bit.sv
// MSB-first serial-to-parallel receiver with a one-deep valid/ready output.
// Optional feature: define DESER_PARITY_EN to append and check an even-parity bit.
module shift_deserializer_8bit
  import shift_link_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             data_in,
  input  logic             ShiftIn,
  input  logic             FrameSync,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Overrun
`ifdef DESER_PARITY_EN
  ,
  output logic             ParityErr
`endif
);

`ifdef DESER_PARITY_EN
  localparam int N  = WIDTH + 1;
  localparam int HW = WIDTH + 1;
`else
  localparam int N  = WIDTH;
  localparam int HW = WIDTH;
`endif
  // Only N-1 bits are ever stored; the final bit goes straight into the word.
  localparam int SRW = N - 1;
  localparam int CW  = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [SRW-1:0] sr;
  logic [CW-1:0]  cnt;
  logic           word_done;
  logic [HW-1:0]  word;
  logic [HW-1:0]  hold_q;
  logic           drop;

  always_comb begin
    // NOTE: every output of this block is assigned on all paths so no latch is inferred.
    word_done = ShiftIn && !FrameSync && (cnt == LAST);
`ifdef DESER_PARITY_EN
    word = {even_parity(32'(sr)) ^ data_in, sr};
`else
    word = {sr, data_in};
`endif
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (FrameSync) begin
      // Realignment throws away any partial word without raising a flag.
      if (ShiftIn) begin
        sr  <= SRW'(data_in);
        cnt <= CW'(1);
      end else begin
        cnt <= '0;
      end
    end else if (ShiftIn) begin
      if (word_done) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
        sr  <= SRW'({sr, data_in});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset)     Overrun <= 1'b0;
    else if (drop) Overrun <= 1'b1;
  end

  deser_hold_stage #(
    .DW (HW)
  ) u_hold (
    .clk        (clk),
    .Reset      (Reset),
    .load_valid (word_done),
    .load_data  (word),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (hold_q),
    .drop_pulse (drop)
  );

  assign parallel_out = hold_q[WIDTH-1:0];
`ifdef DESER_PARITY_EN
  assign ParityErr = hold_q[WIDTH];
`endif

endmodule

// File: tb/tb_shift_deserializer_8bit.sv
// Directed self-checking bench for shift_deserializer_8bit (default and
// DESER_PARITY_EN builds); expected words are hand-computed constants.
module tb_shift_deserializer_8bit;

`ifdef DESER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       data_in = 1'b0;
  logic       ShiftIn = 1'b0;
  logic       FrameSync = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] parallel_out;
  logic       out_valid;
  logic       Overrun;
`ifdef DESER_PARITY_EN
  logic       ParityErr;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cycles = 0;
  int base;

  shift_deserializer_8bit dut (
    .clk          (clk),
    .Reset        (Reset),
    .data_in      (data_in),
    .ShiftIn      (ShiftIn),
    .FrameSync    (FrameSync),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .Overrun      (Overrun)
`ifdef DESER_PARITY_EN
    ,
    .ParityErr    (ParityErr)
`endif
  );

  always #5 clk = ~clk;

  // Counts clock cycles with out_valid high, sampled mid-cycle.
  always @(negedge clk) if (out_valid === 1'b1) valid_cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ShiftIn = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_bit(input logic b, input logic fs);
    data_in   = b;
    ShiftIn   = 1'b1;
    FrameSync = fs;
    @(posedge clk);
    #1;
    ShiftIn   = 1'b0;
    FrameSync = 1'b0;
  endtask

  // Sends one word MSB first (plus parity bit in the parity build); optionally
  // raises out_ready just before the completing strobe.
  task automatic send_bits(input logic [7:0] w, input logic fs_first,
                           input logic ready_last, input logic par);
    for (int i = 0; i < NB; i++) begin
      if (ready_last && i == NB - 1) out_ready = 1'b1;
      strobe_bit((i < 8) ? w[7 - i] : par, fs_first && i == 0);
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    send_bits(w, 1'b0, 1'b0, ^w);
  endtask

  initial begin
    // Reset mid-word
    idle();
    idle();
    Reset = 1'b0;
    strobe_bit(1'b1, 1'b0);
    strobe_bit(1'b1, 1'b0);
    strobe_bit(1'b1, 1'b0);
    Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      idle();
      check("rst_data", parallel_out, 8'h00);
      check("rst_valid", out_valid, 1'b0);
      check("rst_overrun", Overrun, 1'b0);
    end
    Reset = 1'b0;
    out_ready = 1'b1;
    base = valid_cycles;
    send_word(8'hAA);
    check("rst_word_valid", out_valid, 1'b1);
    check("rst_word_data", parallel_out, 8'hAA);
    idle();
    check("rst_word_consumed", out_valid, 1'b0);
    check("rst_word_pulse", valid_cycles - base, 1);

    // Back-to-back words
    base = valid_cycles;
    send_word(8'hAA);
    check("b2b_first", parallel_out, 8'hAA);
    send_word(8'h3C);
    check("b2b_second_valid", out_valid, 1'b1);
    check("b2b_second", parallel_out, 8'h3C);
    check("b2b_overrun", Overrun, 1'b0);
    idle();
    check("b2b_pulses", valid_cycles - base, 2);

    // Overrun
    out_ready = 1'b0;
    send_word(8'h55);
    check("ovr_first", parallel_out, 8'h55);
    check("ovr_flag_clear", Overrun, 1'b0);
    send_word(8'hF0);
    check("ovr_kept", parallel_out, 8'h55);
    check("ovr_flag", Overrun, 1'b1);
    out_ready = 1'b1;
    idle();
    check("ovr_consumed", out_valid, 1'b0);
    check("ovr_sticky", Overrun, 1'b1);
    Reset = 1'b1;
    idle();
    Reset = 1'b0;
    check("ovr_reset", Overrun, 1'b0);

    // Completion and consumption on the same edge
    out_ready = 1'b0;
    send_word(8'h11);
    check("sim_first", parallel_out, 8'h11);
    send_bits(8'h22, 1'b0, 1'b1, ^8'h22);
    check("sim_valid", out_valid, 1'b1);
    check("sim_data", parallel_out, 8'h22);
    check("sim_overrun", Overrun, 1'b0);
    idle();
    check("sim_drained", out_valid, 1'b0);

    // FrameSync realignment with a strobe
    out_ready = 1'b1;
    base = valid_cycles;
    for (int i = 0; i < 5; i++) strobe_bit(1'b1, 1'b0);
    send_bits(8'hC3, 1'b1, 1'b0, ^8'hC3);
    check("fs_data", parallel_out, 8'hC3);
    check("fs_valid", out_valid, 1'b1);
    idle();
    check("fs_single", valid_cycles - base, 1);

    // FrameSync without a strobe clears the partial word
    strobe_bit(1'b0, 1'b0);
    strobe_bit(1'b1, 1'b0);
    strobe_bit(1'b1, 1'b0);
    FrameSync = 1'b1;
    idle();
    FrameSync = 1'b0;
    send_word(8'hA5);
    check("fs_idle_data", parallel_out, 8'hA5);
    check("fs_idle_valid", out_valid, 1'b1);
    idle();

`ifdef DESER_PARITY_EN
    send_bits(8'hAA, 1'b0, 1'b0, 1'b0);
    check("par_ok_data", parallel_out, 8'hAA);
    check("par_ok_err", ParityErr, 1'b0);
    send_bits(8'hAB, 1'b0, 1'b0, 1'b0);
    check("par_bad_valid", out_valid, 1'b1);
    check("par_bad_data", parallel_out, 8'hAB);
    check("par_bad_err", ParityErr, 1'b1);
    idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
